// File: rtl/irq_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared sizes, FSM state encoding and reset values for the
//             interrupt capture front end.
//  Revision : 1.0
// ============================================================================
package irq_pkg;

   localparam int N_REQ = 4;
   localparam int ID_W  = $clog2(N_REQ);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam logic [N_REQ-1:0] PENDING_RST = '0;
   localparam logic [N_REQ-1:0] LOST_RST    = '0;

endpackage
`default_nettype wire

// File: rtl/irq_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_capture_ctrl_if
//  Purpose  : Valid/ready channel carrying the granted request index.
//  Revision : 1.0
// ============================================================================
interface irq_capture_ctrl_if;
   import irq_pkg::*;

   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_ready;

   modport master (output irq_valid, output irq_id, input irq_ready);
   modport slave  (input irq_valid, input irq_id, output irq_ready);

endinterface
`default_nettype wire

// File: rtl/irq_capture_ctrl_pri_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pri_enc
//  Purpose  : Combinational highest-set-bit encoder; index 0 for a zero vector.
//  Revision : 1.0
// ============================================================================
module irq_pri_enc
   import irq_pkg::*;
(
   input  wire logic [N_REQ-1:0] vec_i,
   output logic      [ID_W-1:0]  idx_o,
   output logic                  any_o
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec_i[i]) begin
            idx_o = ID_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_capture_ctrl
//  Purpose  : Synchronises request lines, latches rising edges as pending and
//             presents the highest-priority unmasked one over valid/ready.
//  Revision : 1.0
// ============================================================================
module irq_capture_ctrl
   import irq_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [N_REQ-1:0] req_in,
   input  wire logic [N_REQ-1:0] mask,
   input  wire logic             lost_clr,
   output logic      [N_REQ-1:0] pending,
   output logic      [N_REQ-1:0] lost,
   irq_capture_ctrl_if.master    irq_bus
);

   logic [N_REQ-1:0] sync1_q, sync2_q, sync_d_q;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] lost_q, lost_d;
   logic [N_REQ-1:0] edge_w, clr_w, cand_w;
   logic [ID_W-1:0]  enc_idx_w;
   logic             enc_any_w;
   logic             hs_w;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic [ID_W-1:0]  id_q, id_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sync_d_q <= '0;
      end else begin
         sync1_q  <= req_in;
         sync2_q  <= sync1_q;
         sync_d_q <= sync2_q;
      end
   end

   assign edge_w = sync2_q & ~sync_d_q;
   assign hs_w   = valid_q & irq_bus.irq_ready;
   assign clr_w  = hs_w ? (N_REQ'(1) << id_q) : '0;
   assign cand_w = pending_q & ~mask;

   // Set beats clear; a colliding clear also suppresses the lost flag.
   always_comb begin
      pending_d = (pending_q & ~clr_w) | edge_w;
      lost_d    = lost_q | (edge_w & pending_q & ~clr_w);
      if (lost_clr) begin
         lost_d = '0;
      end
   end

   irq_pri_enc u_enc (
      .vec_i (cand_w),
      .idx_o (enc_idx_w),
      .any_o (enc_any_w)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (enc_any_w) begin
               id_d    = enc_idx_w;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (irq_bus.irq_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         id_q      <= '0;
         pending_q <= PENDING_RST;
         lost_q    <= LOST_RST;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
      end
   end

   assign pending           = pending_q;
   assign lost              = lost_q;
   assign irq_bus.irq_valid = valid_q;
   assign irq_bus.irq_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_capture_ctrl
//  Purpose  : Directed self-checking bench for irq_capture_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_irq_capture_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] req_in;
   logic [3:0] mask;
   logic       lost_clr;
   logic [3:0] pending;
   logic [3:0] lost;
   int         n_checks;
   int         n_errors;
   int         cnt;

   irq_capture_ctrl_if u_if ();

   irq_capture_ctrl u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .mask     (mask),
      .lost_clr (lost_clr),
      .pending  (pending),
      .lost     (lost),
      .irq_bus  (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      req_in         = 4'b0000;
      mask           = 4'b0000;
      lost_clr       = 1'b0;
      u_if.irq_ready = 1'b0;

      // Reset defaults
      tick(3);
      check("rst_valid", {31'd0, u_if.irq_valid}, 32'd0);
      rst = 1'b0;
      tick(1);
      check("rst_pending", {28'd0, pending}, 32'd0);
      check("rst_lost",    {28'd0, lost},    32'd0);
      check("rst_id",      {30'd0, u_if.irq_id}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (u_if.irq_valid) cnt++;
      end
      check("idle_20", cnt, 32'd0);

      // Single request on bit 2
      req_in = 4'b0100;
      tick(3);
      check("single_pend", {28'd0, pending}, 32'h4);
      check("single_nvalid_k2", {31'd0, u_if.irq_valid}, 32'd0);
      tick(1);
      check("single_valid", {31'd0, u_if.irq_valid}, 32'd1);
      check("single_id",    {30'd0, u_if.irq_id},    32'd2);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      check("single_drop",  {31'd0, u_if.irq_valid}, 32'd0);
      check("single_clear", {28'd0, pending}, 32'd0);
      req_in = 4'b0000;
      tick(4);

      // Priority with bit 3 masked
      mask   = 4'b1000;
      req_in = 4'b1011;
      tick(3);
      check("pri_pend", {28'd0, pending}, 32'hB);
      tick(1);
      check("pri_v1",  {31'd0, u_if.irq_valid}, 32'd1);
      check("pri_id1", {30'd0, u_if.irq_id},    32'd1);
      u_if.irq_ready = 1'b1;
      tick(1);
      check("pri_bubble", {31'd0, u_if.irq_valid}, 32'd0);
      check("pri_pend2",  {28'd0, pending}, 32'h9);
      tick(1);
      check("pri_v0",  {31'd0, u_if.irq_valid}, 32'd1);
      check("pri_id0", {30'd0, u_if.irq_id},    32'd0);
      tick(1);
      u_if.irq_ready = 1'b0;
      check("pri_pend3", {28'd0, pending}, 32'h8);
      tick(1);
      check("pri_masked", {31'd0, u_if.irq_valid}, 32'd0);
      mask = 4'b0000;
      tick(1);
      check("pri_v3",  {31'd0, u_if.irq_valid}, 32'd1);
      check("pri_id3", {30'd0, u_if.irq_id},    32'd3);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      check("pri_empty", {28'd0, pending}, 32'd0);
      req_in = 4'b0000;
      tick(4);

      // Stability under stall
      req_in = 4'b0010;
      tick(4);
      check("stall_id_a", {30'd0, u_if.irq_id}, 32'd1);
      req_in = 4'b1010;
      tick(5);
      check("stall_pend",  {28'd0, pending}, 32'hA);
      check("stall_valid", {31'd0, u_if.irq_valid}, 32'd1);
      check("stall_id_b",  {30'd0, u_if.irq_id}, 32'd1);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      check("stall_pend2", {28'd0, pending}, 32'h8);
      tick(1);
      check("stall_next_v",  {31'd0, u_if.irq_valid}, 32'd1);
      check("stall_next_id", {30'd0, u_if.irq_id},    32'd3);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      req_in = 4'b0000;
      tick(4);

      // Lost flag on a second edge of a pending bit
      mask   = 4'b0100;
      req_in = 4'b0100;
      tick(3);
      check("lost_pend", {28'd0, pending}, 32'h4);
      check("lost_none", {28'd0, lost},    32'd0);
      req_in = 4'b0000;
      tick(3);
      req_in = 4'b0100;
      tick(3);
      check("lost_set", {28'd0, lost}, 32'h4);
      lost_clr = 1'b1;
      tick(1);
      lost_clr = 1'b0;
      check("lost_clr", {28'd0, lost}, 32'd0);
      req_in = 4'b0000;
      tick(3);

      // Edge on bit 2 colliding with its own handshake
      mask = 4'b0000;
      tick(1);
      check("coll_pres", {30'd0, u_if.irq_id}, 32'd2);
      req_in = 4'b0100;
      tick(2);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      check("coll_pend",  {28'd0, pending}, 32'h4);
      check("coll_lost",  {28'd0, lost},    32'd0);
      check("coll_drop",  {31'd0, u_if.irq_valid}, 32'd0);
      tick(1);
      check("coll_again", {31'd0, u_if.irq_valid}, 32'd1);
      u_if.irq_ready = 1'b1;
      tick(1);
      u_if.irq_ready = 1'b0;
      check("coll_final", {28'd0, pending}, 32'd0);
      req_in = 4'b0000;
      tick(4);

      // Asynchronous reset while presenting, request held through release
      req_in = 4'b0001;
      tick(4);
      check("mr_valid", {31'd0, u_if.irq_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_async_drop", {31'd0, u_if.irq_valid}, 32'd0);
      check("mr_pend",       {28'd0, pending}, 32'd0);
      tick(2);
      rst = 1'b0;
      u_if.irq_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (u_if.irq_valid) begin
            cnt++;
            check("mr_id", {30'd0, u_if.irq_id}, 32'd0);
         end
         tick(1);
      end
      u_if.irq_ready = 1'b0;
      check("mr_once", cnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
